// File: rtl/axis_if.sv
// AXI4-Stream style valid/ready/data bundle shared by the averager's input and output streams.
// The master drives valid and data; the slave answers with ready.
interface axis_if #(
    parameter int DATA_W = 16
) ();
    logic                     tvalid;
    logic                     tready;
    logic signed [DATA_W-1:0] tdata;

    modport master (output tvalid, output tdata, input  tready);
    modport slave  (input  tvalid, input  tdata, output tready);
endinterface : axis_if

// File: rtl/axis_decimating_averager.sv
// Decimating block averager: emits the signed mean of every 2^R accepted samples, R latched per block.
// Define AXIS_DECIMATING_AVERAGER_ROUNDING_EN for round-half-up; default is floor (plain arithmetic shift).
module axis_decimating_averager #(
    parameter int AXIS_TDATA_WIDTH = 16,
    parameter int MAX_LOG2_RATE    = 10
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic [3:0] log2_rate,
    axis_if.slave      S_AXIS,
    axis_if.master     M_AXIS
);

    localparam int         DATA_W   = AXIS_TDATA_WIDTH;
    // The full-scale sum of 2^MAX_LOG2_RATE samples fits exactly in DATA_W+MAX_LOG2_RATE bits.
    localparam int         ACC_W    = AXIS_TDATA_WIDTH + MAX_LOG2_RATE;
    localparam int         CNT_W    = MAX_LOG2_RATE + 1;
    localparam logic [3:0] MAX_RATE = 4'(MAX_LOG2_RATE);

    // Block state
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic        [CNT_W-1:0]  cnt_q, cnt_d;
    logic        [3:0]        rate_q, rate_d;

    // Output register
    logic                     m_valid_q, m_valid_d;
    logic signed [DATA_W-1:0] m_data_q, m_data_d;

    // Datapath helpers
    logic        [3:0]        rate_in;
    logic        [3:0]        rate_cur;
    logic        [CNT_W-1:0]  last_cnt;
    logic                     is_final;
    logic                     s_ready;
    logic                     accept;
    logic signed [ACC_W-1:0]  sample_ext;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  rounded;
    logic signed [ACC_W-1:0]  avg;

    // NOTE: every variable written here gets a default first, so no path leaves a latch behind.
    always_comb begin
        rate_in  = (log2_rate > MAX_RATE) ? MAX_RATE : log2_rate;
        // An empty block takes the live rate, since that is the value it latches on acceptance.
        rate_cur = (cnt_q == '0) ? rate_in : rate_q;
        last_cnt = (CNT_W'(1) << rate_cur) - CNT_W'(1);
        is_final = (cnt_q == last_cnt);

        s_ready  = !(aresetn && m_valid_q && !M_AXIS.tready && is_final);
        accept   = S_AXIS.tvalid && s_ready;

        sample_ext = {{MAX_LOG2_RATE{S_AXIS.tdata[DATA_W-1]}}, S_AXIS.tdata};
        sum        = acc_q + sample_ext;
`ifdef AXIS_DECIMATING_AVERAGER_ROUNDING_EN
        rounded    = (rate_cur == 4'd0) ? sum : sum + (ACC_W'(1) << (rate_cur - 4'd1));
`else
        rounded    = sum;
`endif
        avg        = rounded >>> rate_cur;

        acc_d     = acc_q;
        cnt_d     = cnt_q;
        rate_d    = rate_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;

        if (m_valid_q && M_AXIS.tready) begin
            m_valid_d = 1'b0;
        end

        if (accept) begin
            if (cnt_q == '0) begin
                rate_d = rate_in;
            end
            if (is_final) begin
                m_data_d  = avg[DATA_W-1:0];
                m_valid_d = 1'b1;
                acc_d     = '0;
                cnt_d     = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            rate_q    <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            rate_q    <= rate_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
        end
    end

    assign S_AXIS.tready = s_ready;
    assign M_AXIS.tvalid = m_valid_q;
    assign M_AXIS.tdata  = m_data_q;

endmodule : axis_decimating_averager

// File: tb/tb_axis_decimating_averager.sv
// Directed self-checking bench for axis_decimating_averager; expected values are hand-computed
// and follow AXIS_DECIMATING_AVERAGER_ROUNDING_EN when the bench is built with it.
module tb_axis_decimating_averager;

    logic       aclk = 1'b0;
    logic       aresetn;
    logic [3:0] log2_rate;

    int n_checks = 0;
    int n_fail   = 0;
    int mon_q[$];

    axis_if #(.DATA_W(16)) s_axis ();
    axis_if #(.DATA_W(16)) m_axis ();

    axis_decimating_averager #(
        .AXIS_TDATA_WIDTH(16),
        .MAX_LOG2_RATE   (10)
    ) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .log2_rate(log2_rate),
        .S_AXIS   (s_axis),
        .M_AXIS   (m_axis)
    );

    always #5 aclk = ~aclk;

    // Record every completed output handshake, sampled mid-cycle.
    always @(negedge aclk) begin
        if (aresetn && m_axis.tvalid && m_axis.tready) mon_q.push_back(int'(m_axis.tdata));
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Present one sample and return at edge+1 just after it is accepted.
    task automatic push(input int v);
        bit done = 0;
        s_axis.tvalid = 1'b1;
        s_axis.tdata  = 16'(v);
        for (int i = 0; i < 64; i++) begin
            #1;
            if (s_axis.tready) begin
                @(posedge aclk);
                #1;
                done = 1;
                break;
            end
            @(posedge aclk);
            #1;
        end
        if (!done) check("push_timeout", int'(s_axis.tready), 1);
    endtask

    task automatic idle(input int n);
        s_axis.tvalid = 1'b0;
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    initial begin
        int exp_avg, exp_neg;
`ifdef AXIS_DECIMATING_AVERAGER_ROUNDING_EN
        exp_avg = 3;
        exp_neg = -3;
`else
        exp_avg = 2;
        exp_neg = -4;
`endif
        aresetn       = 1'b0;
        log2_rate     = 4'd0;
        s_axis.tvalid = 1'b0;
        s_axis.tdata  = '0;
        m_axis.tready = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        check("rst_tvalid", int'(m_axis.tvalid), 0);
        check("rst_tdata", int'(m_axis.tdata), 0);
        check("rst_tready", int'(s_axis.tready), 1);
        aresetn = 1'b1;
        #1;
        check("post_rst_tready", int'(s_axis.tready), 1);

        // Averaging, log2_rate=2: 1,2,3,5 -> 11 >>> 2
        log2_rate = 4'd2;
        push(1); push(2); push(3);
        check("avg_no_early_valid", int'(m_axis.tvalid), 0);
        push(5);
        check("avg_valid", int'(m_axis.tvalid), 1);
        check("avg_data", int'(m_axis.tdata), exp_avg);
        idle(1);
        check("avg_valid_cleared", int'(m_axis.tvalid), 0);

        // Negative values, log2_rate=1: -3,-4 -> -7 >>> 1
        log2_rate = 4'd1;
        push(-3);
        check("neg_no_early_valid", int'(m_axis.tvalid), 0);
        push(-4);
        check("neg_valid", int'(m_axis.tvalid), 1);
        check("neg_data", int'(m_axis.tdata), exp_neg);
        idle(2);

        // Backpressure, log2_rate=1: 10,20 -> 15 held; 30 accepted; 40 stalls
        mon_q.delete();
        m_axis.tready = 1'b0;
        push(10); push(20);
        check("bp_valid", int'(m_axis.tvalid), 1);
        check("bp_data", int'(m_axis.tdata), 15);
        push(30);
        check("bp_held_after_30", int'(m_axis.tdata), 15);
        s_axis.tdata = 16'(40);
        #1;
        check("bp_stall_40", int'(s_axis.tready), 0);
        @(posedge aclk);
        #1;
        check("bp_still_stalled", int'(s_axis.tready), 0);
        check("bp_held_valid", int'(m_axis.tvalid), 1);
        check("bp_held_data", int'(m_axis.tdata), 15);
        m_axis.tready = 1'b1;
        #1;
        check("bp_release_ready", int'(s_axis.tready), 1);
        @(posedge aclk);
        #1;
        check("bp_b2b_valid", int'(m_axis.tvalid), 1);
        check("bp_b2b_data", int'(m_axis.tdata), 35);
        idle(2);
        check("bp_out_count", mon_q.size(), 2);
        if (mon_q.size() == 2) begin
            check("bp_out0", mon_q[0], 15);
            check("bp_out1", mon_q[1], 35);
        end

        // Pass-through, log2_rate=0: back-to-back outputs with 1-cycle latency
        mon_q.delete();
        log2_rate = 4'd0;
        push(7);
        check("pt_data0", int'(m_axis.tdata), 7);
        push(-8);
        check("pt_valid1", int'(m_axis.tvalid), 1);
        check("pt_data1", int'(m_axis.tdata), -8);
        push(32767);
        check("pt_data2", int'(m_axis.tdata), 32767);
        idle(2);
        check("pt_out_count", mon_q.size(), 3);
        if (mon_q.size() == 3) begin
            check("pt_out0", mon_q[0], 7);
            check("pt_out1", mon_q[1], -8);
            check("pt_out2", mon_q[2], 32767);
        end

        // Rate change mid-block: block started at rate 2 keeps 4 samples (sum 40)
        log2_rate = 4'd2;
        push(4); push(8);
        log2_rate = 4'd1;
        push(12);
        check("rc_no_early_valid", int'(m_axis.tvalid), 0);
        push(16);
        check("rc_valid", int'(m_axis.tvalid), 1);
        check("rc_data", int'(m_axis.tdata), 10);
        idle(2);

        // Clamping: log2_rate=15 -> 1024-sample block, sum 103424 -> 101
        log2_rate = 4'd15;
        for (int i = 0; i < 1023; i++) push(100);
        check("clamp_no_early_valid", int'(m_axis.tvalid), 0);
        push(1124);
        check("clamp_valid", int'(m_axis.tvalid), 1);
        check("clamp_data", int'(m_axis.tdata), 101);
        idle(2);

        // Reset mid-block discards the partial sum of 100s
        log2_rate = 4'd2;
        push(100); push(100);
        s_axis.tvalid = 1'b0;
        aresetn = 1'b0;
        @(posedge aclk);
        #1;
        check("mid_rst_tvalid", int'(m_axis.tvalid), 0);
        check("mid_rst_tready", int'(s_axis.tready), 1);
        aresetn = 1'b1;
        mon_q.delete();
        push(8); push(8); push(8);
        check("mid_rst_no_early_valid", int'(m_axis.tvalid), 0);
        push(8);
        check("mid_rst_valid", int'(m_axis.tvalid), 1);
        check("mid_rst_data", int'(m_axis.tdata), 8);
        idle(2);
        check("mid_rst_out_count", mon_q.size(), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_axis_decimating_averager

// File: doc/axis_decimating_averager.md
AXIS_DECIMATING_AVERAGER -- requirements
Module: axis_decimating_averager

Interface
REQ-001 SHALL provide parameter AXIS_TDATA_WIDTH, default 16, giving the signed sample width on both streams.
REQ-002 SHALL provide parameter MAX_LOG2_RATE, default 10, giving the largest supported log2 of the decimation factor.
REQ-003 SHALL have port aclk  input  1  as the single clock; all logic is rising-edge.
REQ-004 SHALL have port aresetn  input  1  as the reset, which is synchronous and active-low.
REQ-005 SHALL have port log2_rate  input  4  giving the requested log2 of the decimation factor N (N = 2^log2_rate).
REQ-006 SHALL have port S_AXIS_tvalid  input  1  as the upstream sample-valid signal (velocity from the differentiator).
REQ-007 SHALL have port S_AXIS_tdata  input  AXIS_TDATA_WIDTH  as the signed two's-complement input sample.
REQ-008 SHALL have port S_AXIS_tready  output  1  to accept or stall the upstream.
REQ-009 SHALL have port M_AXIS_tready  input  1  as the downstream ready signal.
REQ-010 SHALL have port M_AXIS_tvalid  output  1  to indicate that the averaged output is valid.
REQ-011 SHALL have port M_AXIS_tdata  output  AXIS_TDATA_WIDTH  as the signed mean of N input samples.

Function
REQ-012 SHALL accept an input sample only on a cycle with S_AXIS_tvalid=1 and S_AXIS_tready=1.
REQ-013 SHALL latch the effective rate R = min(log2_rate, MAX_LOG2_RATE) when the first sample of a block is accepted; log2_rate changes mid-block SHALL NOT affect that block.
REQ-014 SHALL hold a signed accumulator of AXIS_TDATA_WIDTH+MAX_LOG2_RATE bits and a sample counter of MAX_LOG2_RATE+1 bits.
REQ-015 SHALL, on each accepted non-final sample, add the sign-extended sample to the accumulator and increment the counter.
REQ-016 SHALL treat an accepted sample as final when counter = 2^R-1, and SHALL then load M_AXIS_tdata with (accumulator + sample) >>> R (arithmetic shift, truncated to AXIS_TDATA_WIDTH bits), assert M_AXIS_tvalid on the next cycle, and clear the accumulator and counter.
REQ-017 SHALL, for R=0, act as a one-register pass-through with 1-cycle latency.
REQ-018 SHALL produce an output with a latency of exactly 1 cycle from acceptance of the final sample to M_AXIS_tvalid=1.
REQ-019 SHALL hold M_AXIS_tdata and M_AXIS_tvalid stable while M_AXIS_tvalid=1 and M_AXIS_tready=0.
REQ-020 SHALL clear M_AXIS_tvalid after a cycle with M_AXIS_tvalid=1 and M_AXIS_tready=1, unless a new final sample is accepted in that same cycle, in which case it SHALL load new data and keep M_AXIS_tvalid=1 (back-to-back, no bubble).
REQ-021 SHALL drive S_AXIS_tready = NOT(M_AXIS_tvalid AND NOT M_AXIS_tready AND counter = 2^R-1), so that only a final sample stalls, and only while the output register is occupied and blocked.
REQ-022 SHALL continue accepting non-final samples while the output is blocked.
REQ-023 SHALL never overflow the accumulator: the worst case of N = 2^MAX_LOG2_RATE full-scale samples fits by construction.

Reset
REQ-024 SHALL, while aresetn=0 at a clock edge, clear the accumulator, counter, latched R, and M_AXIS_tdata to 0, and clear M_AXIS_tvalid to 0.
REQ-025 SHALL hold S_AXIS_tready=1 during and immediately after reset.
REQ-026 SHALL discard any partial block on a reset asserted mid-operation, so that the first post-reset output averages only post-reset samples.

Configuration
REQ-027 SHALL, when macro AXIS_DECIMATING_AVERAGER_ROUNDING_EN is defined, add 2^(R-1) to the sum before the shift when R>0 (round-half-up); R=0 is unaffected.
REQ-028 SHALL, without AXIS_DECIMATING_AVERAGER_ROUNDING_EN, truncate toward negative infinity (plain arithmetic shift).

Verification
REQ-029 SHALL verify averaging: log2_rate=2, inputs 1,2,3,5 with continuous valid and tready=1 -> one output of 2 without rounding (11>>>2) or 3 with rounding, exactly 1 cycle after the 4th sample.
REQ-030 SHALL verify negative values: log2_rate=1, inputs -3,-4 -> output -4 without rounding, -3 with rounding.
REQ-031 SHALL verify backpressure: log2_rate=1, M_AXIS_tready=0, inputs 10,20,30,40 -> output 15 held stable, sample 30 accepted, and S_AXIS_tready=0 while 40 is presented; after tready rises, 15 is followed by 35.
REQ-032 SHALL verify pass-through and back-to-back: log2_rate=0, inputs 7,-8,32767 with tready=1 -> outputs 7,-8,32767 on consecutive cycles.
REQ-033 SHALL verify rate change and clamping: log2_rate changes from 2 to 1 after the 2nd sample -> that block still averages 4 samples; log2_rate=15 -> block length 1024.
REQ-034 SHALL verify reset mid-block: log2_rate=2, 2 samples of 100, aresetn=0 for 1 cycle, then 4 samples of 8 -> single output 8, with M_AXIS_tvalid=0 during reset.
